// File: rtl/delay_latency_probe_pkg.sv
// Shared definitions for the delay-line latency probe: FSM states and default sizing.
package delay_latency_probe_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    REPORT = 3'd4
  } state_e;

  localparam int DEFAULT_FLUSH_LEN = 128;
  localparam int DEFAULT_MAX_LAT   = 255;

endpackage

// File: rtl/delay_latency_probe.sv
// Measures the latency of an external delay line by flushing it with zeros,
// launching a one-cycle marker and counting cycles until the marker returns.
module delay_latency_probe
  import delay_latency_probe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FLUSH_LEN = DEFAULT_FLUSH_LEN,
  parameter int MAX_LAT   = DEFAULT_MAX_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] dl_data,
  input  logic [WIDTH-1:0] dl_out,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [7:0]       latency
);

  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_LEN - 1);
  localparam logic [7:0] MAX_LAST   = 8'(MAX_LAT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dl_data_q, dl_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       latency_q, latency_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      cnt_q     <= '0;
      dl_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      latency_q <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      dl_data_q <= dl_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      latency_q <= latency_d;
    end
  end

  // One counter serves both phases: flush length in FLUSH, elapsed cycles in WAIT.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    latency_d = latency_q;

    case (state_q)
      IDLE: begin
        if (start && (pattern != '0)) begin
          pattern_d = pattern;
          timeout_d = 1'b0;
          cnt_d     = 8'd0;
          state_d   = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = LAUNCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LAUNCH: begin
        cnt_d   = 8'd1;
        state_d = WAIT;
      end
      WAIT: begin
        // A match on the last allowed cycle still wins over the timeout.
        if (dl_out == pattern_q) begin
          latency_d = cnt_q;
          done_d    = 1'b1;
          state_d   = REPORT;
        end else if (cnt_q >= MAX_LAST) begin
          timeout_d = 1'b1;
          latency_d = 8'hFF;
          state_d   = REPORT;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    dl_data_d = (state_d == LAUNCH) ? pattern_q : '0;
    busy_d    = (state_d != IDLE);
  end

  assign dl_data = dl_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign latency = latency_q;

endmodule

// File: doc/delay_latency_probe.md
DELAY_LATENCY_PROBE -- requirements
Module: delay_latency_probe

Interface
REQ-001 Parameter WIDTH, default 8: width of the probe data path.
REQ-002 Parameter FLUSH_LEN, default 128: zero-drive cycles before launch; SHALL be at least the longest line under test.
REQ-003 Parameter MAX_LAT, default 255: largest measurable latency in cycles, range 1..255.
REQ-004 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: request a measurement; sampled each cycle.
REQ-007 Port pattern, input, WIDTH: probe marker; latched when start is accepted.
REQ-008 Port dl_data, output, WIDTH: drives the delay-line input.
REQ-009 Port dl_out, input, WIDTH: delay-line output returned to the probe.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port done, output, 1: one-cycle pulse on a successful match.
REQ-012 Port timeout, output, 1: sticky failure flag, cleared by the next accepted start.
REQ-013 Port latency, output, 8: last measured latency; holds until the next result.

Function
REQ-014 States SHALL be IDLE, FLUSH, LAUNCH, WAIT and REPORT, with registered state and outputs.
REQ-015 In IDLE, start=1 with pattern!=0 SHALL latch pattern, clear timeout and go to FLUSH next cycle.
REQ-016 In IDLE, start=1 with pattern==0 SHALL be ignored; the FSM stays in IDLE and no flag changes.
REQ-017 start while busy=1 SHALL be ignored with no effect on the measurement in progress.
REQ-018 In FLUSH, dl_data SHALL be 0 for exactly FLUSH_LEN cycles, then the FSM SHALL enter LAUNCH.
REQ-019 Any dl_out value during FLUSH SHALL be ignored.
REQ-020 LAUNCH SHALL last one cycle with dl_data=latched pattern; this is cycle 0, and the FSM SHALL then enter WAIT.
REQ-021 In WAIT, dl_data SHALL be 0 and the cycle counter SHALL run 1, 2, 3, ...
REQ-022 At cycle k of WAIT, dl_out==latched pattern SHALL end the measurement with latency=k.
- Cycle k is the k-th cycle after cycle 0.
- An ideal N-register line therefore reports N.
REQ-023 Only the first match SHALL count; later matches SHALL be ignored.
REQ-024 If cycle MAX_LAT passes with no match, the probe SHALL set timeout=1 and latency=8'hFF, with no done pulse.
REQ-025 A match at exactly cycle MAX_LAT SHALL be a success, not a timeout.
REQ-026 REPORT SHALL last one cycle, asserting either done (success) or nothing new (timeout), then return to IDLE.
REQ-027 A start presented in the REPORT cycle SHALL be ignored; start is accepted only in IDLE.
REQ-028 The counter SHALL be 8 bits and SHALL saturate, never wrap.

Reset
REQ-029 While rst=1 at a clock edge, the probe SHALL enter IDLE and drive dl_data=0, busy=0, done=0, timeout=0 and latency=0.
REQ-030 The reset clears the latched pattern and the counter.
REQ-031 Reset SHALL take priority over start and over any match.
REQ-032 Reset during any state, including mid-WAIT, SHALL abort the measurement and produce no done or timeout.

Structure
REQ-033 A shared package SHALL hold the state enumeration and the default FLUSH_LEN/MAX_LAT constants.
REQ-034 The block SHALL be one module with no sub-modules.
REQ-035 The FLUSH/WAIT counter SHALL be shared and reloaded at each state entry.

Verification
REQ-036 Ideal 30-stage line model, pattern=8'hA5, start pulse -> done pulses once, latency=30, timeout=0.
REQ-037 Ideal 90-stage line, then 1-stage line, pattern=8'h3C -> latency=90, then latency=1.
REQ-038 dl_out tied to 0, pattern=8'hFF -> timeout=1 and latency=8'hFF; cycle 255 is the last cycle without a match; no done pulse.
REQ-039 pattern=0 with start -> busy stays 0; a start repeated mid-WAIT on a 45-stage line -> a single result, latency=45.
REQ-040 rst=1 for one cycle at WAIT cycle 20 on a 60-stage line -> all outputs 0 next cycle and no done at cycle 60.
REQ-041 A subsequent start -> latency=60.
